// File: rtl/lin_interp.sv
// Linear-interpolation upsampler: emits 2^LOG2L values per input sample that ramp
// from the previous sample toward the current one (first-order hold).
module lin_interp #(
    parameter int WIDTH = 12,
    parameter int LOG2L = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    underrun
);

    localparam int AW = WIDTH + LOG2L + 1;

    typedef enum logic [1:0] {
        EMPTY,
        PRIME,
        RUN
    } state_t;

    state_t                  state, state_n;
    logic signed [WIDTH-1:0] cur, cur_n;
    logic signed [WIDTH-1:0] nxt, nxt_n;
    logic signed [WIDTH-1:0] pend, pend_n;
    logic                    pend_v, pend_v_n;
    logic signed [WIDTH:0]   step, step_n;
    logic signed [AW-1:0]    acc, acc_n;
    logic [LOG2L-1:0]        k, k_n;
    logic                    underrun_n;
    logic                    in_xfer, out_xfer, seg_end;

    function automatic logic signed [WIDTH:0] diff(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
        return {a[WIDTH-1], a} - {b[WIDTH-1], b};
    endfunction

    function automatic logic signed [AW-1:0] scale(input logic signed [WIDTH-1:0] v);
        return {v[WIDTH-1], v, {LOG2L{1'b0}}};
    endfunction

    // Taking the bits above the fraction is an arithmetic shift, i.e. floor division by L.
    assign out_data = acc[LOG2L +: WIDTH];

    always_comb begin
        state_n    = state;
        cur_n      = cur;
        nxt_n      = nxt;
        pend_n     = pend;
        pend_v_n   = pend_v;
        step_n     = step;
        acc_n      = acc;
        k_n        = k;
        underrun_n = 1'b0;

        out_valid = (state == RUN);
        in_ready  = ~rst & ~((state == RUN) & pend_v);
        in_xfer   = in_valid & in_ready;
        out_xfer  = out_valid & out_ready;
        seg_end   = out_xfer & (k == '1);

        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    cur_n   = in_data;
                    state_n = PRIME;
                end
            end
            PRIME: begin
                if (in_xfer) begin
                    nxt_n   = in_data;
                    acc_n   = scale(cur);
                    step_n  = diff(in_data, cur);
                    k_n     = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (in_xfer && !seg_end) begin
                    pend_n   = in_data;
                    pend_v_n = 1'b1;
                end
                if (out_xfer && !seg_end) begin
                    acc_n = acc + {{LOG2L{step[WIDTH]}}, step};
                    k_n   = k + LOG2L'(1);
                end
                // Segment end: the skid entry wins; otherwise a same-cycle input bypasses it.
                if (seg_end) begin
                    cur_n = nxt;
                    if (pend_v) begin
                        nxt_n    = pend;
                        step_n   = diff(pend, nxt);
                        acc_n    = scale(nxt);
                        k_n      = '0;
                        pend_v_n = 1'b0;
                    end else if (in_xfer) begin
                        nxt_n  = in_data;
                        step_n = diff(in_data, nxt);
                        acc_n  = scale(nxt);
                        k_n    = '0;
                    end else begin
                        state_n    = PRIME;
                        underrun_n = 1'b1;
                    end
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            cur      <= '0;
            nxt      <= '0;
            pend     <= '0;
            pend_v   <= 1'b0;
            step     <= '0;
            acc      <= '0;
            k        <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            cur      <= cur_n;
            nxt      <= nxt_n;
            pend     <= pend_n;
            pend_v   <= pend_v_n;
            step     <= step_n;
            acc      <= acc_n;
            k        <= k_n;
            underrun <= underrun_n;
        end
    end

endmodule

// File: tb/tb_lin_interp.sv
// Bench for lin_interp: a sample-queue model checked every cycle, plus directed ramps
// with literal expectations and a randomized phase.
module tb_lin_interp;

    localparam int WIDTH = 12;
    localparam int LOG2L = 3;
    localparam int L     = 1 << LOG2L;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic signed [WIDTH-1:0] in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic                    underrun;

    lin_interp #(.WIDTH(WIDTH), .LOG2L(LOG2L)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: samples held (accepted, not yet retired) and output index in the current pair.
    int q[$];
    int mk = 0;
    bit exp_under = 1'b0;
    bit started = 1'b0;

    int log_q[$];
    int under_cnt = 0;
    int valid_cycles = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    function automatic int interp(input int a, input int b, input int kk);
        int n;
        int qt;
        n  = kk * (b - a);
        qt = n / L;
        if ((n % L) != 0 && n < 0) qt = qt - 1;
        return a + qt;
    endfunction

    always @(negedge clk) begin
        bit inx;
        bit outx;
        bit segend;
        if (started) begin
            chk("out_valid", int'(out_valid), int'(q.size() >= 2));
            chk("in_ready", int'(in_ready), int'(!rst && q.size() < 3));
            chk("underrun", int'(underrun), int'(exp_under));
            if (q.size() >= 2 && out_valid)
                chk("out_data", int'(out_data), interp(q[0], q[1], mk));
            if (!rst && out_valid && out_ready) log_q.push_back(int'(out_data));
            if (underrun) under_cnt++;
            if (out_valid) valid_cycles++;
        end
        if (rst) begin
            q.delete();
            mk = 0;
            exp_under = 1'b0;
            started = 1'b1;
        end else if (started) begin
            inx = in_valid && (q.size() < 3);
            outx = out_ready && (q.size() >= 2);
            segend = 1'b0;
            exp_under = 1'b0;
            if (outx) begin
                if (mk == L - 1) segend = 1'b1;
                else mk++;
            end
            if (inx) q.push_back(int'(in_data));
            if (segend) begin
                void'(q.pop_front());
                mk = 0;
                if (q.size() < 2) exp_under = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        log_q.delete();
        under_cnt = 0;
        valid_cycles = 0;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data = WIDTH'(v);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        timeout("send");
    endtask

    task automatic wait_under();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (underrun) begin
                chk("under_valid", int'(out_valid), 0);
                tick();
                return;
            end
        end
        timeout("wait_under");
    endtask

    task automatic wait_log(input int n);
        for (int t = 0; t < 100; t++) begin
            if (log_q.size() >= n) return;
            tick();
        end
        timeout("wait_log");
    endtask

    task automatic check_log(input string name, input int exp[$]);
        chk({name, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk(name, log_q[i], exp[i]);
    endtask

    initial begin
        int exp[$];
        int mode;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp[$];
        int pin;
        int pout;

        // Reset state
        reset_dut();
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_under", int'(underrun), 0);
        chk("rst_ready", int'(in_ready), 1);
        tick();

        // Basic ramp 0 -> 80
        reset_dut();
        send(0);
        send(80);
        chk("first_valid", int'(out_valid), 1);
        chk("first_data", int'(out_data), 0);
        wait_under();
        exp = '{0, 10, 20, 30, 40, 50, 60, 70};
        check_log("ramp", exp);

        // Negative step with floor rounding
        reset_dut();
        send(100);
        send(93);
        wait_under();
        exp = '{100, 99, 98, 97, 96, 95, 94, 93};
        check_log("neg", exp);

        // Full-scale range
        reset_dut();
        send(-2048);
        send(2047);
        wait_under();
        chk("fs_len", log_q.size(), 8);
        if (log_q.size() == 8) begin
            chk("fs_0", log_q[0], -2048);
            chk("fs_1", log_q[1], -1537);
            chk("fs_7", log_q[7], 1535);
        end

        // Backpressure at k = 3 with a third sample parked in the skid entry
        reset_dut();
        send(0);
        send(80);
        wait_log(3);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = WIDTH'(40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", int'(out_data), 30);
            if (i > 0) chk("stall_ready", int'(in_ready), 0);
            tick();
            if (i == 0) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        wait_under();
        exp = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 75, 70, 65, 60, 55, 50, 45};
        check_log("bp", exp);

        // Bypass: third sample offered exactly on the k = 7 transfer cycle
        reset_dut();
        send(0);
        send(80);
        wait_log(7);
        in_valid = 1'b1;
        in_data = WIDTH'(0);
        tick();
        in_valid = 1'b0;
        wait_under();
        exp = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 70, 60, 50, 40, 30, 20, 10};
        check_log("bypass", exp);
        chk("bypass_valid_cycles", valid_cycles, 16);
        chk("bypass_underruns", under_cnt, 1);

        // Reset mid-segment
        reset_dut();
        send(0);
        send(80);
        wait_log(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_q.delete();
        @(negedge clk);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_under", int'(underrun), 0);
        tick();
        send(8);
        send(16);
        wait_under();
        exp = '{8, 9, 10, 11, 12, 13, 14, 15};
        check_log("midrst", exp);

        // Randomized traffic, rates changing every 500 cycles, occasional reset
        reset_dut();
        pin = 2;
        pout = 3;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 500 == 0) begin
                pin = $urandom_range(1, 8);
                pout = $urandom_range(1, 4);
            end
            rst = ($urandom_range(0, 399) == 0);
            in_valid = ($urandom_range(1, 8) <= pin);
            out_ready = ($urandom_range(1, 4) <= pout);
            case ($urandom_range(0, 7))
                0: in_data = {1'b1, {(WIDTH-1){1'b0}}};
                1: in_data = {1'b0, {(WIDTH-1){1'b1}}};
                default: in_data = WIDTH'($urandom);
            endcase
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
